alu_mul_div_sequencer: RTL

Multi-cycle 8-bit unsigned multiply/divide engine that acts as the initiator on the ALU operand/op/flag interface. It drives val_a, val_b and op toward the clocked ALU and consumes its result, carry and negative flags to run shift-add multiply or restoring divide. It sits beside the datapath controller, which requests an operation with a start pulse and collects a 16-bit result.

---
 rtl/alu_mul_div_sequencer_pkg.sv | 10 +
 rtl/alu_mul_div_sequencer.sv | 90 +++++++++
 2 files changed

// File: rtl/alu_mul_div_sequencer_pkg.sv
// alu_mul_div_sequencer_pkg: ALU opcodes and sequencer state encoding.
package alu_mul_div_sequencer_pkg;
    localparam int WIDTH = 8;
    localparam int ITER  = 8;
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_SHL = 4'b0101;
    localparam logic [3:0] OP_SHR = 4'b0110;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
endpackage

// File: rtl/alu_mul_div_sequencer.sv
// alu_mul_div_sequencer: multi-cycle unsigned shift-add multiply / restoring divide driving an external clocked ALU.
module alu_mul_div_sequencer
    import alu_mul_div_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] opnd_a,
    input  logic [WIDTH-1:0] opnd_b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] alu_val_a,
    output logic [WIDTH-1:0] alu_val_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_neg
);
    state_t state, state_next;
    logic is_div, msb, accept, by_zero, last, take;
    logic [WIDTH-1:0] opnd, cap_hi, cap_lo, src_hi, src_lo, src_opnd, ld_hi, ld_lo;
    logic [2:0] cnt;
    logic src_div;

    assign accept  = state == S_IDLE && start;
    assign by_zero = mode && opnd_b == '0;
    assign last    = cnt == 3'(ITER - 1);
    assign busy    = state == S_ISSUE || state == S_WAIT;
    assign done    = state == S_DONE;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  state_next = start ? (by_zero ? S_DONE : S_ISSUE) : S_IDLE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  state_next = last ? S_DONE : S_ISSUE;
            default: state_next = S_IDLE;
        endcase
    end

    // msb carries the 9th remainder bit lost by the shift when the divisor exceeds 127
    assign take   = msb | ~alu_neg;
    assign cap_hi = is_div ? (take ? alu_result : res_hi) : {alu_carry, alu_result[7:1]};
    assign cap_lo = is_div ? {res_lo[7:1], take} : {alu_result[0], res_lo[7:1]};

    assign src_div  = accept ? mode : is_div;
    assign src_hi   = accept ? '0 : cap_hi;
    assign src_lo   = accept ? (mode ? opnd_a : opnd_b) : cap_lo;
    assign src_opnd = accept ? (mode ? opnd_b : opnd_a) : opnd;
    assign {ld_hi, ld_lo} = src_div ? {src_hi, src_lo} << 1 : {src_hi, src_lo};

    always_ff @(posedge clk) begin
        if (rst) begin
            {div0, is_div, msb, cnt, opnd} <= '0;
            {res_hi, res_lo, alu_val_a, alu_val_b} <= '0;
            alu_op <= OP_ADD;
        end else if (accept && by_zero) begin
            div0   <= 1'b1;
            res_hi <= opnd_a;
            res_lo <= 8'hFF;
            cnt    <= '0;
        end else if (accept || (state == S_WAIT && !last)) begin
            if (accept) begin
                div0   <= 1'b0;
                is_div <= mode;
                opnd   <= src_opnd;
            end
            cnt       <= accept ? '0 : cnt + 3'd1;
            res_hi    <= ld_hi;
            res_lo    <= ld_lo;
            msb       <= src_div & src_hi[7];
            alu_val_a <= ld_hi;
            alu_val_b <= src_div ? src_opnd : (src_lo[0] ? src_opnd : '0);
            alu_op    <= src_div ? OP_SUB : OP_ADD;
        end else if (state == S_WAIT) begin
            res_hi <= cap_hi;
            res_lo <= cap_lo;
            cnt    <= cnt + 3'd1;
        end
    end
endmodule
